// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches one 8-word cache block, one word at a time, and writes the tag after the last word.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start the fill at the missed word and wrap within the block.
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int OFFSET_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [ADDR_W-1:0] memory_data_in,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] memory_address,
  output logic [ADDR_W-1:0] memory_data_out
);

  localparam int CNT_W  = OFFSET_BITS - 1;
  localparam int BASE_W = ADDR_W - OFFSET_BITS;
  localparam logic [CNT_W-1:0] LAST_WORD = '1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_q;
  logic [BASE_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  words_q;
  logic              busy_q;
  logic [CNT_W-1:0]  start_cnt;
  logic              in_fill;
  logic              unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_cnt        = miss_address[OFFSET_BITS-1:1];
  assign unused_addr_bits = miss_address[0];
`else
  assign start_cnt        = '0;
  assign unused_addr_bits = ^miss_address[OFFSET_BITS-1:0];
`endif

  // words_q counts returned words independently of the fetch offset, so the
  // tag is written with the 8th word whichever offset the fill started at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q  <= miss_address[ADDR_W-1:OFFSET_BITS];
            cnt_q   <= start_cnt;
            words_q <= '0;
            busy_q  <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (memory_data_valid) begin
            cnt_q   <= cnt_q + 1'b1;
            words_q <= words_q + 1'b1;
            if (words_q == LAST_WORD) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_fill          = (state_q == FILL);
  assign fsm_busy         = busy_q;
  assign write_data_array = in_fill & memory_data_valid;
  assign write_tag_array  = in_fill & memory_data_valid & (words_q == LAST_WORD);
  assign memory_data_out  = in_fill ? memory_data_in : '0;

  // The requested word stays put until it returns; only one word is outstanding.
  assign memory_address = in_fill ? {base_q, cnt_q, 1'b0}
                                  : {miss_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: vector table, directed fills and a randomized run against a block-fill model.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data_in;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] memory_address;
  logic [15:0] memory_data_out;

  cache_fill_fsm #(.ADDR_W(16), .OFFSET_BITS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_in    (memory_data_in),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .memory_address    (memory_address),
    .memory_data_out   (memory_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Block-fill model: which block, which word it began at, how many words returned.
  bit m_busy  = 1'b0;
  int m_base  = 0;
  int m_start = 0;
  int m_n     = 0;

  logic [15:0] cap[$];
  int          tags;
  logic [15:0] tag_addr;
  int          busy_cycles;

  typedef struct {
    logic        rst;
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] din;
    logic        busy;
    logic        wd;
    logic        wt;
    logic [15:0] maddr;
    logic [15:0] dout;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_cycle(input string nm);
    logic        e_busy, e_wd, e_wt;
    logic [15:0] e_addr, e_dout;
    #2;
    if (!rst) m_busy = 1'b0;
    if (!m_busy) begin
      e_busy = 1'b0; e_wd = 1'b0; e_wt = 1'b0; e_dout = 16'h0;
      e_addr = {miss_address[15:4], 4'h0};
    end else begin
      e_busy = 1'b1;
      e_wd   = memory_data_valid;
      e_wt   = memory_data_valid && (m_n == 7);
      e_dout = memory_data_in;
      e_addr = 16'(m_base * 16 + ((m_start + m_n) % 8) * 2);
    end
    chk({nm, ".busy"}, {15'h0, fsm_busy},         {15'h0, e_busy});
    chk({nm, ".wdata"}, {15'h0, write_data_array}, {15'h0, e_wd});
    chk({nm, ".wtag"}, {15'h0, write_tag_array},   {15'h0, e_wt});
    chk({nm, ".addr"}, memory_address, e_addr);
    chk({nm, ".dout"}, memory_data_out, e_dout);
    if (fsm_busy) busy_cycles++;
    if (write_data_array) cap.push_back(memory_address);
    if (write_tag_array) begin
      tags++;
      tag_addr = memory_address;
    end
    @(posedge clk);
    if (rst) begin
      if (!m_busy) begin
        if (miss_detected) begin
          m_busy  = 1'b1;
          m_base  = int'(miss_address) / 16;
          m_start = CWF ? (int'(miss_address) % 16) / 2 : 0;
          m_n     = 0;
        end
      end else if (memory_data_valid) begin
        m_n++;
        if (m_n == 8) m_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Memory with 4-cycle word latency; optionally wiggles miss inputs during the fill.
  task automatic serve(input string nm, input bit toggle, input int stop_words);
    int lat = 0;
    int guard = 0;
    while (m_busy && !(stop_words > 0 && cap.size() == stop_words)) begin
      if (guard == 200) begin
        chk({nm, ".timeout"}, 16'h1, 16'h0);
        break;
      end
      guard++;
      memory_data_valid = (lat == 3);
      lat = (lat == 3) ? 0 : lat + 1;
      memory_data_in = 16'($urandom);
      if (toggle) begin
        miss_detected = 1'($urandom);
        miss_address  = $urandom_range(0, 1) ? 16'h0080 : 16'h0046;
      end else begin
        miss_detected = 1'b0;
      end
      run_cycle(nm);
    end
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
  endtask

  task automatic do_fill(input string nm, input logic [15:0] a, input bit toggle, input int stop_words);
    cap.delete();
    tags = 0;
    busy_cycles = 0;
    miss_detected = 1'b1;
    miss_address = a;
    memory_data_valid = 1'b0;
    run_cycle(nm);
    serve(nm, toggle, stop_words);
  endtask

  vec_t vecs[6];
  logic [15:0] s_addr, s_addr2;
  logic [15:0] exp46[8];

  initial begin
    s_addr  = CWF ? 16'h0046 : 16'h0040;
    s_addr2 = CWF ? 16'h0048 : 16'h0042;
    vecs[0] = '{1'b0, 1'b1, 16'h0046, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0046, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0046, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0080, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, s_addr,   16'h2222};
    vecs[4] = '{1'b1, 1'b1, 16'h0080, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b0, s_addr,   16'h3333};
    vecs[5] = '{1'b1, 1'b1, 16'h0080, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, s_addr2,  16'h4444};
    if (CWF) exp46 = '{16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E, 16'h0040, 16'h0042, 16'h0044};
    else     exp46 = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E};

    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_in = 16'h0; memory_data_valid = 1'b0;
    @(negedge clk);

    // Vector table: reset hold, valid ignored in IDLE, miss accept, first word.
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst; miss_detected = vecs[i].miss; miss_address = vecs[i].addr;
      memory_data_valid = vecs[i].valid; memory_data_in = vecs[i].din;
      #2;
      chk($sformatf("vec%0d.busy", i),  {15'h0, fsm_busy},         {15'h0, vecs[i].busy});
      chk($sformatf("vec%0d.wdata", i), {15'h0, write_data_array}, {15'h0, vecs[i].wd});
      chk($sformatf("vec%0d.wtag", i),  {15'h0, write_tag_array},  {15'h0, vecs[i].wt});
      chk($sformatf("vec%0d.addr", i),  memory_address, vecs[i].maddr);
      chk($sformatf("vec%0d.dout", i),  memory_data_out, vecs[i].dout);
      @(posedge clk);
      if (rst) begin
        if (!m_busy && miss_detected) begin
          m_busy = 1'b1; m_base = int'(miss_address) / 16;
          m_start = CWF ? (int'(miss_address) % 16) / 2 : 0; m_n = 0;
        end else if (m_busy && memory_data_valid) begin
          m_n++;
        end
      end
      @(negedge clk);
    end
    serve("drain", 1'b0, 0);
    $display("table: vectors applied, block drained");

    // Full in-order fill from 0x0000.
    do_fill("fill0", 16'h0000, 1'b0, 0);
    chk("fill0.words", 16'(cap.size()), 16'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk($sformatf("fill0.order%0d", i), cap[i], 16'(2 * i));
    chk("fill0.tags", 16'(tags), 16'd1);
    chk("fill0.tag_addr", tag_addr, 16'h000E);
    chk("fill0.busy_cycles", 16'(busy_cycles), 16'd32);
    $display("fill 0x0000: words=%0d tags=%0d busy=%0d", cap.size(), tags, busy_cycles);

    // Fill at 0x0046 while miss inputs toggle; no restart, stays in block.
    do_fill("fill46", 16'h0046, 1'b1, 0);
    chk("fill46.words", 16'(cap.size()), 16'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk($sformatf("fill46.order%0d", i), cap[i], exp46[i]);
    chk("fill46.tags", 16'(tags), 16'd1);
    chk("fill46.tag_addr", tag_addr, CWF ? 16'h0044 : 16'h004E);
    $display("fill 0x0046: words=%0d tag_addr=%h", cap.size(), tag_addr);

    // Valid pulses in IDLE must not write anything.
    cap.delete(); tags = 0;
    for (int i = 0; i < 3; i++) begin
      miss_detected = 1'b0; memory_data_valid = 1'b1; memory_data_in = 16'hBEEF;
      miss_address = 16'h1234;
      run_cycle("idle_valid");
    end
    memory_data_valid = 1'b0;
    chk("idle_valid.writes", 16'(cap.size() + tags), 16'd0);
    $display("idle valid pulses: writes=%0d", cap.size() + tags);

    // Reset after 3 words aborts without a tag, then a fresh fill from word 0.
    do_fill("abort", 16'h0020, 1'b0, 3);
    rst = 1'b0; memory_data_valid = 1'b0; miss_detected = 1'b0;
    run_cycle("abort_rst");
    chk("abort.tags", 16'(tags), 16'd0);
    rst = 1'b1;
    do_fill("refill", 16'h0010, 1'b0, 0);
    chk("refill.words", 16'(cap.size()), 16'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk($sformatf("refill.order%0d", i), cap[i], 16'(16'h0010 + 2 * i));
    $display("abort+refill: words=%0d first=%h", cap.size(), cap.size() > 0 ? cap[0] : 16'hxxxx);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      miss_detected = ($urandom_range(0, 3) == 0);
      miss_address = 16'($urandom);
      memory_data_valid = 1'($urandom);
      memory_data_in = 16'($urandom);
      run_cycle("rand");
    end
    $display("random: 400 cycles applied");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
